// File: rtl/simpson_operand_loader_pkg.sv
// Shared definitions for the Simpson operand loader: state encoding,
// job word count and the slot each operand occupies in the replay order.
package simpson_operand_loader_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int NUM_WORDS      = 6;

  localparam logic [2:0] IDX_A0   = 3'd0;
  localparam logic [2:0] IDX_A1   = 3'd1;
  localparam logic [2:0] IDX_A2   = 3'd2;
  localparam logic [2:0] IDX_A3   = 3'd3;
  localparam logic [2:0] IDX_X_LO = 3'd4;
  localparam logic [2:0] IDX_X_HI = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PRESS    = 3'd2,
    GAP      = 3'd3,
    WAIT_RES = 3'd4,
    DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/simpson_operand_loader_if.sv
// Host-side job interface of the operand loader: job request with its six
// operands, and the status/result returned when the job completes.
interface simpson_operand_loader_if
  import simpson_operand_loader_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  logic              start;
  logic [DATA_W-1:0] a0;
  logic [DATA_W-1:0] a1;
  logic [DATA_W-1:0] a2;
  logic [DATA_W-1:0] a3;
  logic [DATA_W-1:0] x_lo;
  logic [DATA_W-1:0] x_hi;
  logic              busy;
  logic              done;
  logic              range_err;
  logic [DATA_W-1:0] result_out;

  modport master (
    output start, a0, a1, a2, a3, x_lo, x_hi,
    input  busy, done, range_err, result_out
  );

  modport slave (
    input  start, a0, a1, a2, a3, x_lo, x_hi,
    output busy, done, range_err, result_out
  );

endinterface

// File: rtl/simpson_operand_loader.sv
// Replays a six-word job onto the fsm switch/button inputs with fixed
// setup/press/gap timing, then captures the fsm result after a fixed wait.
module simpson_operand_loader
  import simpson_operand_loader_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SETUP_CYC   = 1,
  parameter int PRESS_CYC   = 6,
  parameter int GAP_CYC     = 3,
  parameter int RESULT_WAIT = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  simpson_operand_loader_if.slave    host,
  output logic [DATA_W-1:0]          sw,
  output logic                       btn,
  input  logic [DATA_W-1:0]          result_in
);

  localparam int MAX_SP  = (SETUP_CYC > PRESS_CYC) ? SETUP_CYC : PRESS_CYC;
  localparam int MAX_GW  = (GAP_CYC > RESULT_WAIT) ? GAP_CYC : RESULT_WAIT;
  localparam int CNT_MAX = (MAX_SP > MAX_GW) ? MAX_SP : MAX_GW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Phase counter reload values: each phase lasts exactly its cycle count.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PRESS_LD = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(RESULT_WAIT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] words [NUM_WORDS];

  // Job sequencer: FSM, phase counter, word file and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= IDX_A0;
      sw              <= '0;
      btn             <= 1'b0;
      host.busy       <= 1'b0;
      host.done       <= 1'b0;
      host.range_err  <= 1'b0;
      host.result_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          host.done <= 1'b0;
          if (host.start) begin
            words[IDX_A0]   <= host.a0;
            words[IDX_A1]   <= host.a1;
            words[IDX_A2]   <= host.a2;
            words[IDX_A3]   <= host.a3;
            words[IDX_X_LO] <= host.x_lo;
            words[IDX_X_HI] <= host.x_hi;
            idx             <= IDX_A0;
            sw              <= host.a0;
            cnt             <= SETUP_LD;
            host.busy       <= 1'b1;
            state           <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            btn   <= 1'b1;
            cnt   <= PRESS_LD;
            state <= PRESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            btn   <= 1'b0;
            cnt   <= GAP_LD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (idx == IDX_X_HI) begin
              cnt   <= WAIT_LD;
              state <= WAIT_RES;
            end else begin
              // sw only ever moves here, with btn already low
              idx   <= idx + 3'd1;
              sw    <= words[idx + 3'd1];
              cnt   <= SETUP_LD;
              state <= SETUP;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_RES: begin
          if (cnt == '0) begin
            host.done       <= 1'b1;
            host.result_out <= result_in;
            host.range_err  <= (words[IDX_X_LO] > words[IDX_X_HI]);
            state           <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          host.done <= 1'b0;
          host.busy <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          btn       <= 1'b0;
          host.busy <= 1'b0;
          host.done <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simpson_operand_loader.sv
// Directed bench: loader drives a behavioural fsm stand-in that latches each
// pressed word and returns a weighted sum (or 16'hFFFF when x_lo > x_hi).
module tb_simpson_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw;
  logic        btn;
  logic [15:0] result_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  simpson_operand_loader_if #(.DATA_W(16)) bus ();

  simpson_operand_loader #(
    .DATA_W(16), .SETUP_CYC(1), .PRESS_CYC(6), .GAP_CYC(3), .RESULT_WAIT(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(bus),
    .sw(sw),
    .btn(btn),
    .result_in(result_in)
  );

  // fsm stand-in: latch sw on each btn rise, answer once six words are in
  logic [15:0] got [6];
  logic [2:0]  got_n = 3'd0;
  logic        btn_d = 1'b0;
  logic        fsm_clr = 1'b0;

  always @(posedge clk) begin
    btn_d <= btn;
    if (fsm_clr) got_n <= 3'd0;
    else if (btn && !btn_d && got_n < 3'd6) begin
      got[got_n] <= sw;
      got_n      <= got_n + 3'd1;
    end
  end

  always_comb begin
    result_in = 16'h0BAD;
    if (got_n == 3'd6) begin
      if (got[4] > got[5]) result_in = 16'hFFFF;
      else result_in = got[0] + 16'd2 * got[1] + 16'd3 * got[2] + 16'd4 * got[3]
                       + 16'd5 * got[4] + 16'd6 * got[5];
    end
  end

  // per-cycle protocol monitor
  logic [15:0] seq [64];
  int          plen [64];
  int          pn = 0, hi_len = 0, low_len = 0;
  int          sw_glitch = 0, bad_gap = 0, done_wide = 0, done_n = 0;
  logic        prev_btn = 1'b0, prev_done = 1'b0;
  logic [15:0] prev_sw = 16'd0;

  always @(negedge clk) begin
    if (btn && prev_btn && sw !== prev_sw) sw_glitch <= sw_glitch + 1;
    if (btn && !prev_btn) begin
      if (pn > 0 && low_len < 3) bad_gap <= bad_gap + 1;
      if (pn < 64) seq[pn] <= sw;
      hi_len <= 1;
    end else if (btn) begin
      hi_len <= hi_len + 1;
    end
    if (!btn && prev_btn) begin
      if (pn < 64) plen[pn] <= hi_len;
      pn <= pn + 1;
    end
    low_len <= btn ? 0 : low_len + 1;
    if (bus.done && prev_done) done_wide <= done_wide + 1;
    if (bus.done && !prev_done) done_n <= done_n + 1;
    prev_btn  <= btn;
    prev_done <= bus.done;
    prev_sw   <= sw;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] v0, v1, v2, v3, v4, v5);
    bus.a0 = v0; bus.a1 = v1; bus.a2 = v2; bus.a3 = v3; bus.x_lo = v4; bus.x_hi = v5;
  endtask

  task automatic run_job(input logic [15:0] w0, w1, w2, w3, w4, w5,
                         input logic [15:0] exp_res, input logic exp_rerr,
                         input bit poke, output time t_done);
    logic [15:0] w [6];
    int base;
    int cyc;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
    base = pn;
    set_ops(w0, w1, w2, w3, w4, w5);
    bus.start = 1'b1;
    fsm_clr   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    fsm_clr   = 1'b0;
    set_ops(16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5);
    check("busy_after_start", bus.busy, 1);
    check("btn_in_setup", btn, 0);
    check("sw_first_word", sw, w0);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (poke && (cyc == 10 || cyc == 40)) begin
        bus.start = 1'b1;
        set_ops(16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    t_done = $time;
    check("done_cycle", cyc, 81);
    check("busy_in_done", bus.busy, 1);
    check("result_out", bus.result_out, exp_res);
    check("range_err", bus.range_err, exp_rerr);
    check("sw_holds_last", sw, w5);
    check("press_count", pn - base, 6);
    for (int i = 0; i < 6; i++) begin
      check("word_seq", seq[base + i], w[i]);
      check("press_len", plen[base + i], 6);
    end
    @(posedge clk); #1;
    check("done_pulse_end", bus.done, 0);
    check("busy_after_done", bus.busy, 0);
    check("sw_after_done", sw, w5);
  endtask

  time t1, t2;
  int  ndone;

  initial begin
    bus.start = 1'b0;
    set_ops(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_btn", btn, 0);
    check("rst_range_err", bus.range_err, 0);
    check("rst_sw", sw, 0);
    check("rst_result", bus.result_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(16'd7, 16'd0, 16'd0, 16'd0, 16'd7, 16'd16, 16'd138, 1'b0, 1'b0, t1);

    run_job(16'd1, 16'd3, 16'd0, 16'd0, 16'd2, 16'd8, 16'd65, 1'b0, 1'b0, t1);
    run_job(16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 16'd6, 16'd52, 1'b0, 1'b0, t2);
    check("b2b_spacing", 32'((t2 - t1) / 10), 82);

    run_job(16'd2, 16'd0, 16'd5, 16'd0, 16'd3, 16'd9, 16'd86, 1'b0, 1'b1, t1);

    run_job(16'd1, 16'd1, 16'd1, 16'd1, 16'd5, 16'd4, 16'hFFFF, 1'b1, 1'b0, t1);

    // abort during the third press
    set_ops(16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9);
    bus.start = 1'b1;
    fsm_clr   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    fsm_clr   = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    check("third_press_btn", btn, 1);
    check("third_press_sw", sw, 16'd4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_btn", btn, 0);
    check("abort_sw", sw, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result_out, 0);
    check("abort_range_err", bus.range_err, 0);
    ndone = done_n;
    repeat (100) @(posedge clk);
    #1;
    check("abort_no_done", done_n, ndone);
    check("abort_idle_btn", btn, 0);

    run_job(16'd4, 16'd2, 16'd1, 16'd0, 16'd1, 16'd6, 16'd52, 1'b0, 1'b0, t1);

    check("done_pulses", done_n, 6);
    check("sw_stable_while_btn", sw_glitch, 0);
    check("gap_min", bad_gap, 0);
    check("done_width", done_wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
